// File: rtl/queue_reader_if.sv
// Handshake bundle between queue_reader, the monitor event queue and the evaluation stage.
// master = queue_reader side, slave = queue + downstream side.
interface queue_reader_if #(
  parameter int unsigned DATA_W = 64
) ();
  logic                     q_pop;
  logic                     q_pop_valid;
  logic signed [DATA_W-1:0] q_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;

  modport master (
    output q_pop,
    input  q_pop_valid,
    input  q_data,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport slave (
    input  q_pop,
    output q_pop_valid,
    output q_data,
    input  out_valid,
    output out_ready,
    input  out_data
  );
endinterface

// File: rtl/queue_reader.sv
// Consumer end of the monitor event queue: credit-limited pops into a small skid FIFO,
// valid/ready delivery downstream, and throttled polling after an empty pop response.
module queue_reader #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  queue_reader_if.master   bus,
  output logic [CNT_W-1:0] empty_polls,
  output logic             busy
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned UW = CW + 1;
  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned GW = $clog2(POLL_GAP + 1);

  typedef enum logic {ST_RUN, ST_BACKOFF} state_t;

  state_t                   r_state;
  logic [GW-1:0]            r_gap;
  logic [CW-1:0]            r_count;
  logic [PW-1:0]            r_rptr;
  logic [PW-1:0]            r_wptr;
  logic                     r_inflight;
  logic [CNT_W-1:0]         r_empty_polls;
  logic signed [DATA_W-1:0] r_out_data;
  logic signed [DATA_W-1:0] r_mem [BUF_DEPTH];

  logic                     w_fire;
  logic                     w_push;
  logic                     w_empty_resp;
  logic [UW-1:0]            w_used;
  logic                     w_pop;
  logic [CW-1:0]            w_count_nxt;
  logic [PW-1:0]            w_rptr_nxt;
  logic signed [DATA_W-1:0] w_head_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check counts the in-flight pop and frees the slot leaving this cycle.
  assign w_fire       = (r_count != '0) & bus.out_ready;
  assign w_push       = r_inflight & bus.q_pop_valid;
  assign w_empty_resp = r_inflight & ~bus.q_pop_valid;
  assign w_used       = UW'(r_count) + UW'(r_inflight) - UW'(w_fire);
  assign w_pop        = ~rst & en & (r_state == ST_RUN) & ~w_empty_resp
                      & (w_used < UW'(BUF_DEPTH));

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_fire);
  assign w_rptr_nxt  = w_fire ? ptr_inc(r_rptr) : r_rptr;

  // Next head: bypass the incoming event when the FIFO drains to empty this cycle.
  always_comb begin
    w_head_nxt = r_out_data;
    if (w_count_nxt != '0) begin
      if (r_count == CW'(w_fire)) w_head_nxt = bus.q_data;
      else                        w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.q_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_gap         <= '0;
      r_count       <= '0;
      r_rptr        <= '0;
      r_wptr        <= '0;
      r_inflight    <= 1'b0;
      r_empty_polls <= '0;
      r_out_data    <= '0;
    end else begin
      r_inflight <= w_pop;
      r_count    <= w_count_nxt;
      r_rptr     <= w_rptr_nxt;
      r_out_data <= w_head_nxt;
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_empty_resp && (r_empty_polls != '1)) r_empty_polls <= r_empty_polls + 1'b1;

      // Backoff leaves RUN for POLL_GAP-1 cycles; the empty-response cycle is the first idle one.
      case (r_state)
        ST_RUN: begin
          if (w_empty_resp) begin
            r_gap <= GW'(POLL_GAP);
            if (POLL_GAP > 1) r_state <= ST_BACKOFF;
          end
        end
        ST_BACKOFF: begin
          r_gap <= r_gap - 1'b1;
          if (r_gap <= GW'(2)) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.q_pop     = w_pop;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_out_data;
  assign empty_polls   = r_empty_polls;
  assign busy          = (r_count != '0) | r_inflight;

endmodule

// File: tb/tb_queue_reader.sv
// Directed bench for queue_reader against a depth-5 queue model that answers one cycle after q_pop.
module tb_queue_reader;
  localparam int unsigned DATA_W = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] empty_polls;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic signed [DATA_W-1:0] qm [$];

  queue_reader_if #(.DATA_W(DATA_W)) qif ();

  queue_reader #(
    .DATA_W(DATA_W), .BUF_DEPTH(2), .POLL_GAP(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(qif),
    .empty_polls(empty_polls), .busy(busy)
  );

  always #5 clk = ~clk;

  // Queue model: pop of an empty queue answers valid=0, data=0.
  always @(posedge clk) begin
    if (qif.q_pop && (qm.size() > 0)) begin
      qif.q_pop_valid <= 1'b1;
      qif.q_data      <= qm.pop_front();
    end else begin
      qif.q_pop_valid <= 1'b0;
      qif.q_data      <= '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    qif.out_ready = 1'b0;
    qm.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    qm.push_back(64'sd5);
    en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) rst = 1'b1;
      if (c == 5) rst = 1'b0;
      #1;
      case (c)
        2: begin
          checks++;
          if (qif.out_valid !== 1'b1 || qif.out_data !== 64'sd5) begin
            errors++;
            $display("FAIL reset_prehead valid=%0b data=%0d want 1/5", qif.out_valid, qif.out_data);
          end
        end
        3: begin
          checks++;
          if (empty_polls !== 4'd1 || qif.q_pop !== 1'b0) begin
            errors++;
            $display("FAIL reset_preempty polls=%0d q_pop=%0b want 1/0", empty_polls, qif.q_pop);
          end
        end
        4: begin
          checks++;
          if ({qif.q_pop, qif.out_valid, busy, empty_polls} !== 7'b0 || qif.out_data !== 64'sd0) begin
            errors++;
            $display("FAIL reset_vals pop=%0b valid=%0b busy=%0b polls=%0d data=%0d want all 0",
                     qif.q_pop, qif.out_valid, busy, empty_polls, qif.out_data);
          end
        end
        5: begin
          checks++;
          if ({qif.q_pop, qif.out_valid, busy, empty_polls} !== 7'b1000000 || qif.out_data !== 64'sd0) begin
            errors++;
            $display("FAIL reset_release pop=%0b valid=%0b busy=%0b polls=%0d data=%0d want 1/0/0/0/0",
                     qif.q_pop, qif.out_valid, busy, empty_polls, qif.out_data);
          end
        end
        default: ;
      endcase
      tick();
    end
  endtask

  task automatic test_drain();
    logic [0:9] e_pop   = 10'b1111000010;
    logic [0:9] e_valid = 10'b0011100000;
    int         e_data [10] = '{0, 0, 1, 2, 3, 3, 3, 3, 3, 3};
    do_reset();
    qm.push_back(64'sd1); qm.push_back(64'sd2); qm.push_back(64'sd3);
    qif.out_ready = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (qif.q_pop !== e_pop[c] || qif.out_valid !== e_valid[c] || qif.out_data !== 64'(e_data[c])) begin
        errors++;
        $display("FAIL drain c%0d pop=%0b valid=%0b data=%0d want %0b/%0b/%0d",
                 c, qif.q_pop, qif.out_valid, qif.out_data, e_pop[c], e_valid[c], e_data[c]);
      end
      if (c == 5 || c == 9) begin
        checks++;
        if (empty_polls !== 4'd1) begin
          errors++;
          $display("FAIL drain_polls c%0d got %0d want 1", c, empty_polls);
        end
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [0:9] e_pop   = 10'b1100001100;
    logic [0:9] e_valid = 10'b0011111110;
    int         e_data [10] = '{0, 0, 10, 10, 10, 10, 10, 20, 30, 30};
    do_reset();
    qm.push_back(64'sd10); qm.push_back(64'sd20); qm.push_back(64'sd30);
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) qif.out_ready = 1'b1;
      #1;
      checks++;
      if (qif.q_pop !== e_pop[c] || qif.out_valid !== e_valid[c] || qif.out_data !== 64'(e_data[c])) begin
        errors++;
        $display("FAIL backpressure c%0d pop=%0b valid=%0b data=%0d want %0b/%0b/%0d",
                 c, qif.q_pop, qif.out_valid, qif.out_data, e_pop[c], e_valid[c], e_data[c]);
      end
      checks++;
      if (dut.r_count > 2'd2) begin
        errors++;
        $display("FAIL backpressure_count c%0d got %0d want <=2", c, dut.r_count);
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic signed [DATA_W-1:0] nxt = 64'sd105;
    do_reset();
    for (int i = 100; i < 105; i++) qm.push_back(64'(i));
    qif.out_ready = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (nxt <= 64'sd109 && qm.size() < 5) begin
        qm.push_back(nxt);
        nxt = nxt + 64'sd1;
      end
      #1;
      checks++;
      if (qif.q_pop !== (c <= 10) || qif.out_valid !== (c >= 2)
          || qif.out_data !== ((c >= 2) ? 64'(98 + c) : 64'sd0)) begin
        errors++;
        $display("FAIL stream c%0d pop=%0b valid=%0b data=%0d want %0b/%0b/%0d", c,
                 qif.q_pop, qif.out_valid, qif.out_data, (c <= 10), (c >= 2), (c >= 2) ? 98 + c : 0);
      end
      checks++;
      if (dut.r_count > 2'd2) begin
        errors++;
        $display("FAIL stream_count c%0d got %0d want <=2", c, dut.r_count);
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_enable();
    logic [0:16] e_pop = 17'b10000010000100001;
    do_reset();
    qm.push_back(64'sd7);
    qif.out_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      en = (c == 0) || (c >= 6);
      #1;
      checks++;
      if (qif.q_pop !== e_pop[c]) begin
        errors++;
        $display("FAIL enable_pop c%0d got %0b want %0b", c, qif.q_pop, e_pop[c]);
      end
      case (c)
        1: begin
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL enable_busy_inflight got %0b want 1", busy);
          end
        end
        2: begin
          checks++;
          if (qif.out_valid !== 1'b1 || qif.out_data !== 64'sd7) begin
            errors++;
            $display("FAIL enable_capture valid=%0b data=%0d want 1/7", qif.out_valid, qif.out_data);
          end
        end
        3: begin
          checks++;
          if (qif.out_valid !== 1'b0 || busy !== 1'b0 || qif.out_data !== 64'sd7) begin
            errors++;
            $display("FAIL enable_idle valid=%0b busy=%0b data=%0d want 0/0/7",
                     qif.out_valid, busy, qif.out_data);
          end
        end
        8, 13: begin
          checks++;
          if (empty_polls !== ((c == 8) ? 4'd1 : 4'd2)) begin
            errors++;
            $display("FAIL enable_polls c%0d got %0d want %0d", c, empty_polls, (c == 8) ? 1 : 2);
          end
        end
        default: ;
      endcase
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 109; c++) begin
      if (c == 105) qm.push_back(64'sd55);
      if (c == 106) begin rst = 1'b1; en = 1'b0; end
      if (c == 107) rst = 1'b0;
      #1;
      case (c)
        50, 105: begin
          checks++;
          if (empty_polls !== ((c == 50) ? 4'd10 : 4'd15)) begin
            errors++;
            $display("FAIL sat_polls c%0d got %0d want %0d", c, empty_polls, (c == 50) ? 10 : 15);
          end
        end
        106: begin
          checks++;
          if (qif.q_pop !== 1'b0) begin
            errors++;
            $display("FAIL sat_pop_in_reset got %0b want 0", qif.q_pop);
          end
        end
        107, 108: begin
          checks++;
          if ({qif.q_pop, qif.out_valid, busy, empty_polls} !== 7'b0 || qif.out_data !== 64'sd0) begin
            errors++;
            $display("FAIL sat_discard c%0d pop=%0b valid=%0b busy=%0b polls=%0d data=%0d want all 0",
                     c, qif.q_pop, qif.out_valid, busy, empty_polls, qif.out_data);
          end
        end
        default: ;
      endcase
      tick();
    end
  endtask

  initial begin
    qif.out_ready = 1'b0;
    test_reset();
    test_drain();
    test_backpressure();
    test_back_to_back();
    test_enable();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
